spi_rom_ctrl: RTL and testbench

Sequencer for the board's alternative boot-ROM path: turns a longword read request from the ROM region decode into a complete SPI flash read transaction on SPI_CS_n/SPI_CLK/SPI_MOSI/SPI_MISO and returns 32 bits with a one-cycle acknowledge. It sits between the slave-cycle ROM decode, which drives `req`/`addr` and consumes `ack` for DTACK generation, and the serial flash pins. Read-only; flash programming is out of scope.

---
 rtl/spi_rom_ctrl_pkg.sv | 44 ++++
 rtl/spi_bit_engine.sv | 91 +++++++++
 rtl/spi_rom_ctrl.sv | 140 ++++++++++++++
 tb/tb_spi_rom_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_rom_ctrl_pkg.sv
// Shared types and constants for the SPI boot-ROM read sequencer.
// SPI_FAST_READ_EN selects FAST READ (0x0B + 8 dummy clocks) instead of READ (0x03).
package spi_rom_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_CMD     = 3'd2,
    ST_ADDR    = 3'd3,
    ST_DUMMY   = 3'd4,
    ST_DATA    = 3'd5,
    ST_DONE    = 3'd6,
    ST_RELEASE = 3'd7
  } state_e;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;

  localparam int CMD_BITS   = 8;
  localparam int ADDR_BITS  = 24;
  localparam int DUMMY_BITS = 8;
  localparam int DATA_BITS  = 32;

`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] OPCODE   = OP_FAST_READ;
  localparam int         HDR_BITS = CMD_BITS + ADDR_BITS + DUMMY_BITS;
`else
  localparam logic [7:0] OPCODE   = OP_READ;
  localparam int         HDR_BITS = CMD_BITS + ADDR_BITS;
`endif

  localparam int XFER_BITS = HDR_BITS + DATA_BITS;

  localparam logic [6:0] CMD_LAST  = 7'(CMD_BITS - 1);
  localparam logic [6:0] ADDR_LAST = 7'(CMD_BITS + ADDR_BITS - 1);
  localparam logic [6:0] HDR_LAST  = 7'(HDR_BITS - 1);
  localparam logic [6:0] XFER_LAST = 7'(XFER_BITS - 1);

  // Outgoing 40-bit frame: opcode, address, then zeros (dummy clocks / data phase).
  function automatic logic [39:0] build_header(input logic [23:0] byte_addr);
    return {OPCODE, byte_addr, 8'h00};
  endfunction

endpackage

// File: rtl/spi_bit_engine.sv
// SPI mode-0 bit engine: clock divider, SPI_CLK, MOSI/MISO shifters, bit counter, done strobe.
// Frame length follows SPI_FAST_READ_EN through the package constants.
module spi_bit_engine
  import spi_rom_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [39:0] tx_i,
  input  logic        miso_i,
  output logic        sclk_o,
  output logic        mosi_o,
  output logic        bit_adv_o,
  output logic        done_o,
  output logic [6:0]  bit_cnt_o,
  output logic [31:0] rx_o
);

  localparam int             DW       = $clog2(CLK_DIV) + 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

  logic          active_q;
  logic          sclk_q;
  logic          mosi_q;
  logic          done_q;
  logic [DW-1:0] div_q;
  logic [6:0]    bit_q;
  logic [39:0]   tx_q;
  logic [31:0]   rx_q;

  // Asserted in the last cycle of a bit's high phase; the falling edge follows.
  assign bit_adv_o = active_q && sclk_q && (div_q == DIV_LAST);
  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;
  assign done_o    = done_q;
  assign bit_cnt_o = bit_q;
  assign rx_o      = rx_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      done_q   <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort_i) begin
        active_q <= 1'b0;
        sclk_q   <= 1'b0;
        mosi_q   <= 1'b0;
        div_q    <= '0;
      end else if (start_i) begin
        active_q <= 1'b1;
        sclk_q   <= 1'b0;
        mosi_q   <= tx_i[39];
        tx_q     <= {tx_i[38:0], 1'b0};
        div_q    <= '0;
        bit_q    <= '0;
      end else if (active_q) begin
        if (div_q == DIV_LAST) begin
          div_q <= '0;
          if (!sclk_q) begin
            sclk_q <= 1'b1;
            rx_q   <= {rx_q[30:0], miso_i};
          end else begin
            sclk_q <= 1'b0;
            if (bit_q == XFER_LAST) begin
              active_q <= 1'b0;
              done_q   <= 1'b1;
              mosi_q   <= 1'b0;
            end else begin
              bit_q  <= bit_q + 7'd1;
              mosi_q <= tx_q[39];
              tx_q   <= {tx_q[38:0], 1'b0};
            end
          end
        end else begin
          div_q <= div_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_rom_ctrl.sv
// Boot-ROM longword read over SPI flash: request FSM and ack handshake around spi_bit_engine.
// SPI_FAST_READ_EN adds the DUMMY phase and uses opcode 0x0B.
module spi_rom_ctrl
  import spi_rom_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        req,
  input  logic [23:0] addr,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  input  logic        SPI_MISO,
  output logic        SPI_MOSI,
  output logic        SPI_CLK,
  output logic        SPI_CS_n,
  output state_e      dbg_state
);

  state_e      state_q;
  logic [23:0] addr_q;
  logic        cs_n_q;
  logic        ack_q;
  logic        busy_q;
  logic [31:0] rdata_q;
  logic        rel_ok_q;

  logic        in_xfer;
  logic        eng_start;
  logic        eng_abort;
  logic        eng_bit_adv;
  logic        eng_done;
  logic [6:0]  eng_bit_cnt;
  logic [31:0] eng_rx;

  // Handshake: req is a level held for the whole slave cycle; one request yields at most
  // one transfer and one single-cycle ack (rdata valid with it). Dropping req mid-transfer
  // aborts without ack, and a new transfer needs req low in RELEASE first.
  assign in_xfer   = state_q inside {ST_SETUP, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA};
  assign eng_abort = in_xfer && !req;
  assign eng_start = (state_q == ST_SETUP) && req;

  spi_bit_engine #(.CLK_DIV(CLK_DIV)) u_engine (
    .clk_i     (CLK),
    .rst_ni    (RESET_n),
    .start_i   (eng_start),
    .abort_i   (eng_abort),
    .tx_i      (build_header(addr_q)),
    .miso_i    (SPI_MISO),
    .sclk_o    (SPI_CLK),
    .mosi_o    (SPI_MOSI),
    .bit_adv_o (eng_bit_adv),
    .done_o    (eng_done),
    .bit_cnt_o (eng_bit_cnt),
    .rx_o      (eng_rx)
  );

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      cs_n_q   <= 1'b1;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      rdata_q  <= '0;
      rel_ok_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      if (eng_abort) begin
        cs_n_q   <= 1'b1;
        rel_ok_q <= 1'b0;
        state_q  <= ST_RELEASE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (req) begin
              addr_q  <= addr & ~24'h3;
              cs_n_q  <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= ST_SETUP;
            end
          end
          ST_SETUP: state_q <= ST_CMD;
          ST_CMD: begin
            if (eng_bit_adv && eng_bit_cnt == CMD_LAST) state_q <= ST_ADDR;
          end
          ST_ADDR: begin
            if (eng_bit_adv && eng_bit_cnt == ADDR_LAST) begin
`ifdef SPI_FAST_READ_EN
              state_q <= ST_DUMMY;
`else
              state_q <= ST_DATA;
`endif
            end
          end
`ifdef SPI_FAST_READ_EN
          ST_DUMMY: begin
            if (eng_bit_adv && eng_bit_cnt == HDR_LAST) state_q <= ST_DATA;
          end
`endif
          ST_DATA: begin
            if (eng_done) begin
              cs_n_q  <= 1'b1;
              ack_q   <= 1'b1;
              rdata_q <= eng_rx;
              state_q <= ST_DONE;
            end
          end
          // The DONE cycle already counts as one chip-select-high cycle.
          ST_DONE: begin
            rel_ok_q <= 1'b1;
            state_q  <= ST_RELEASE;
          end
          ST_RELEASE: begin
            if (rel_ok_q && !req) begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              rel_ok_q <= 1'b1;
            end
          end
          default: begin
            cs_n_q   <= 1'b1;
            rel_ok_q <= 1'b0;
            state_q  <= ST_RELEASE;
          end
        endcase
      end
    end
  end

  assign SPI_CS_n  = cs_n_q;
  assign ack       = ack_q;
  assign busy      = busy_q;
  assign rdata     = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_rom_ctrl.sv
// Directed bench for spi_rom_ctrl: flash model on CLK_DIV=1 instance, timing probe on CLK_DIV=3.
// Works for both builds (SPI_FAST_READ_EN defined or not).
module tb_spi_rom_ctrl;
  import spi_rom_ctrl_pkg::*;

`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] EXP_OP = 8'h0B;
  localparam int         B_BITS = 72;
`else
  localparam logic [7:0] EXP_OP = 8'h03;
  localparam int         B_BITS = 64;
`endif
  localparam int HDR  = B_BITS - 32;
  localparam int ACK1 = 2 + 2 * B_BITS;
  localparam int ACK3 = 2 + 6 * B_BITS;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT with CLK_DIV=1
  logic        req;
  logic [23:0] addr;
  logic [31:0] rdata;
  logic        ack, busy, miso, mosi, sclk, cs_n;
  state_e      dbg_state;

  // DUT with CLK_DIV=3
  logic        req3;
  logic [23:0] addr3 = 24'h000010;
  logic [31:0] rdata3;
  logic        ack3, busy3, mosi3, sclk3, cs_n3;
  logic        miso3 = 1'b1;
  state_e      dbg3;

  spi_rom_ctrl #(.CLK_DIV(1)) u_dut (
    .CLK(clk), .RESET_n(rst_n), .req(req), .addr(addr), .rdata(rdata), .ack(ack),
    .busy(busy), .SPI_MISO(miso), .SPI_MOSI(mosi), .SPI_CLK(sclk), .SPI_CS_n(cs_n),
    .dbg_state(dbg_state)
  );

  spi_rom_ctrl #(.CLK_DIV(3)) u_dut3 (
    .CLK(clk), .RESET_n(rst_n), .req(req3), .addr(addr3), .rdata(rdata3), .ack(ack3),
    .busy(busy3), .SPI_MISO(miso3), .SPI_MOSI(mosi3), .SPI_CLK(sclk3), .SPI_CS_n(cs_n3),
    .dbg_state(dbg3)
  );

  // scoreboard
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // flash contents
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'h001234: return 8'hDE;
      24'h001235: return 8'hAD;
      24'h001236: return 8'hBE;
      24'h001237: return 8'hEF;
      default:    return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic flash_bit(input int n, input logic [23:0] a);
    int k;
    logic [7:0] b;
    if (n < HDR || n >= HDR + 32) return 1'b0;
    k = n - HDR;
    b = flash_byte(a + 24'(k / 8));
    return b[7 - (k % 8)];
  endfunction

  // flash model, sampled mid-cycle; MISO changes only after a SPI_CLK rise has been seen
  logic [39:0] cap       = '0;
  logic [23:0] fl_addr   = '0;
  int          nrise     = 0;
  int          cs_win    = 0;
  logic        sclk_prev = 1'b0;
  logic        cs_prev   = 1'b1;

  always @(negedge clk) begin
    if (cs_prev && !cs_n) begin
      cs_win++;
      cap = '0;
    end
    cs_prev = cs_n;
    if (cs_n) begin
      nrise     = 0;
      sclk_prev = 1'b0;
    end else begin
      if (sclk && !sclk_prev) begin
        if (nrise < 40) cap = {cap[38:0], mosi};
        nrise++;
        if (nrise == 32) fl_addr = cap[23:0];
      end
      sclk_prev = sclk;
    end
    miso = flash_bit(nrise, fl_addr);
  end

  int ack_cnt = 0;
  always @(negedge clk) if (ack) ack_cnt++;

  // driver: raise req, check acceptance, run to ack (bounded)
  task automatic xfer1(input logic [23:0] a, output int ack_cyc, output int rise_cyc);
    @(posedge clk); #1;
    addr = a;
    req  = 1'b1;
    @(posedge clk); #1;
    check("cs_n_low_after_accept", cs_n, 1'b0);
    check("busy_after_accept", busy, 1'b1);
    ack_cyc  = 0;
    rise_cyc = -1;
    while (!ack && ack_cyc < 600) begin
      @(posedge clk); #1;
      ack_cyc++;
      if (sclk && rise_cyc < 0) rise_cyc = ack_cyc;
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, rise, rise2, base_ack, base_win;
    logic prev;
    rst_n = 1'b0; req = 1'b0; addr = '0; req3 = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_ack", ack, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;

    // basic read, unaligned address
    base_ack = ack_cnt;
    exp_q.push_back(32'hDEADBEEF);
    xfer1(24'h001236, cyc, rise);
    check("ack_cycle_a", cyc, ACK1);
    check("first_rise_a", rise, 2);
    check("rdata_a", rdata, exp_q.pop_front());
    check("mosi_frame_a", cap, {EXP_OP, 24'h001234, 8'h00});
    check("cs_n_at_ack_a", cs_n, 1'b1);
    check("sclk_at_ack_a", sclk, 1'b0);
    @(posedge clk); #1;
    check("ack_one_cycle_a", ack, 1'b0);
    req = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("busy_cleared_a", busy, 1'b0);
    check("idle_after_a", dbg_state, ST_IDLE);
    check("ack_count_a", ack_cnt - base_ack, 1);

    // abort during ADDR bit 10 (transfer bit 18)
    base_ack = ack_cnt;
    @(posedge clk); #1;
    addr = 24'h000100;
    req  = 1'b1;
    @(posedge clk); #1;
    repeat (37) @(posedge clk);
    #1;
    check("abort_in_addr", dbg_state, ST_ADDR);
    req = 1'b0;
    @(posedge clk); #1;
    check("abort_cs_n", cs_n, 1'b1);
    check("abort_sclk", sclk, 1'b0);
    check("abort_state", dbg_state, ST_RELEASE);
    check("abort_rdata", rdata, 32'hDEADBEEF);
    repeat (10) @(posedge clk); #1;
    check("abort_no_ack", ack_cnt - base_ack, 0);
    check("abort_busy", busy, 1'b0);
    check("abort_rdata_kept", rdata, 32'hDEADBEEF);

    // next request completes; req then held 300 cycles past ack
    base_ack = ack_cnt;
    base_win = cs_win;
    exp_q.push_back(32'h5A5B5859);
    xfer1(24'h000102, cyc, rise);
    check("ack_cycle_b", cyc, ACK1);
    check("rdata_b", rdata, exp_q.pop_front());
    check("mosi_frame_b", cap, {EXP_OP, 24'h000100, 8'h00});
    repeat (300) @(posedge clk); #1;
    check("hold_busy", busy, 1'b1);
    check("hold_state", dbg_state, ST_RELEASE);
    check("hold_ack_count", ack_cnt - base_ack, 1);
    check("hold_cs_windows", cs_win - base_win, 1);
    req = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("hold_release_busy", busy, 1'b0);

    // fresh transfer after release
    exp_q.push_back(32'hAAABA8A9);
    xfer1(24'h0000F1, cyc, rise);
    check("ack_cycle_c", cyc, ACK1);
    check("rdata_c", rdata, exp_q.pop_front());
    check("mosi_frame_c", cap, {EXP_OP, 24'h0000F0, 8'h00});
    req = 1'b0;
    repeat (3) @(posedge clk); #1;

    // asynchronous reset in DATA
    addr = 24'h001234;
    req  = 1'b1;
    @(posedge clk); #1;
    repeat (100) @(posedge clk);
    #1;
    check("pre_reset_state", dbg_state, ST_DATA);
    check("pre_reset_sclk", sclk, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_cs_n", cs_n, 1'b1);
    check("reset_sclk", sclk, 1'b0);
    check("reset_mosi", mosi, 1'b0);
    check("reset_ack", ack, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_rdata", rdata, 32'h0);
    req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // CLK_DIV=3 timing
    @(posedge clk); #1;
    req3 = 1'b1;
    @(posedge clk); #1;
    cyc = 0; rise = -1; rise2 = -1; prev = sclk3;
    while (!ack3 && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
      if (sclk3 && !prev) begin
        if (rise < 0) rise = cyc;
        else if (rise2 < 0) rise2 = cyc;
      end
      prev = sclk3;
    end
    check("div3_ack_cycle", cyc, ACK3);
    check("div3_first_rise", rise, 4);
    check("div3_sclk_period", rise2 - rise, 6);
    check("div3_rdata", rdata3, 32'hFFFFFFFF);
    check("div3_cs_n_at_ack", cs_n3, 1'b1);
    req3 = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("div3_busy", busy3, 1'b0);
    check("div3_idle", dbg3, ST_IDLE);
    check("div3_mosi", mosi3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
